// File: rtl/avst_word_rx.sv
// avst_word_rx: Avalon-ST byte-stream receiver that packs each packet into one WORD_BYTES word, MSB byte first.
// Define AVST_WORD_RX_ERRCNT_EN to add the saturating length-error counter on err_count.
module avst_word_rx #(
    parameter int WORD_BYTES = 4,
    parameter int CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              data_in,
    input  logic                    end_in,
    input  logic                    valid_in,
    output logic                    ready_in,
    output logic [8*WORD_BYTES-1:0] word_out,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic                    len_err
`ifdef AVST_WORD_RX_ERRCNT_EN
    ,
    output logic [CNT_W-1:0]        err_count
`endif
);
    localparam int W  = 8 * WORD_BYTES;
    localparam int CW = $clog2(WORD_BYTES + 1);
    localparam logic [CW-1:0] FULL = CW'(WORD_BYTES);
    localparam logic [CW-1:0] LAST = CW'(WORD_BYTES - 1);

    localparam logic [1:0] ST_ACC     = 2'd0;
    localparam logic [1:0] ST_DISCARD = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    if (WORD_BYTES < 2 || WORD_BYTES > 8 || CNT_W < 1) begin : g_param_check
        $error("avst_word_rx: WORD_BYTES must be 2..8 and CNT_W at least 1");
    end

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_word;
    logic          r_word_valid;
    logic          r_ready;
    logic          r_len_err;

    logic          w_accept;
    logic          w_len_err_set;
    logic [W-1:0]  w_acc_next;

    assign w_accept   = valid_in && r_ready;
    assign w_acc_next = {r_acc[W-9:0], data_in};
    // An end beat is wrong-length unless it is exactly the last byte of a word collected in ACC.
    assign w_len_err_set = w_accept && end_in &&
                           ((r_state == ST_ACC && r_cnt != LAST) || r_state == ST_DISCARD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_ACC;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_ready      <= 1'b1;
            r_len_err    <= 1'b0;
        end else begin
            r_len_err <= w_len_err_set;
            case (r_state)
                ST_ACC: begin
                    if (w_accept) begin
                        if (!end_in) begin
                            if (r_cnt == FULL) begin
                                r_state <= ST_DISCARD;
                                r_cnt   <= '0;
                                r_acc   <= '0;
                            end else begin
                                r_acc <= w_acc_next;
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end else if (r_cnt == LAST) begin
                            r_word       <= w_acc_next;
                            r_word_valid <= 1'b1;
                            r_ready      <= 1'b0;
                            r_cnt        <= '0;
                            r_acc        <= '0;
                            r_state      <= ST_HOLD;
                        end else begin
                            r_cnt <= '0;
                            r_acc <= '0;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (w_accept && end_in) begin
                        r_state <= ST_ACC;
                    end
                end
                ST_HOLD: begin
                    if (word_ready) begin
                        r_word_valid <= 1'b0;
                        r_ready      <= 1'b1;
                        r_state      <= ST_ACC;
                    end
                end
                default: begin
                    r_state      <= ST_ACC;
                    r_word_valid <= 1'b0;
                    r_ready      <= 1'b1;
                end
            endcase
        end
    end

    assign ready_in   = r_ready;
    assign word_out   = r_word;
    assign word_valid = r_word_valid;
    assign len_err    = r_len_err;

`ifdef AVST_WORD_RX_ERRCNT_EN
    logic [CNT_W-1:0] r_err_count;

    // Counts in step with len_err being raised and sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_len_err_set && r_err_count != {CNT_W{1'b1}}) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_avst_word_rx.sv
// tb_avst_word_rx: directed self-checking bench for avst_word_rx with hand-computed expected words.
// The err_count scenario is built only when AVST_WORD_RX_ERRCNT_EN is defined (DUT then uses CNT_W=2).
module tb_avst_word_rx;
    localparam int WB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    dataIn;
    logic          endIn;
    logic          validIn;
    logic          readyIn;
    logic [31:0]   wordOut;
    logic          wordValid;
    logic          wordReady;
    logic          lenErr;
`ifdef AVST_WORD_RX_ERRCNT_EN
    logic [1:0]    errCount;
`endif

    int checks = 0;
    int fails  = 0;

    avst_word_rx #(
        .WORD_BYTES(WB)
`ifdef AVST_WORD_RX_ERRCNT_EN
        , .CNT_W(2)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (dataIn),
        .end_in     (endIn),
        .valid_in   (validIn),
        .ready_in   (readyIn),
        .word_out   (wordOut),
        .word_valid (wordValid),
        .word_ready (wordReady),
        .len_err    (lenErr)
`ifdef AVST_WORD_RX_ERRCNT_EN
        , .err_count(errCount)
`endif
    );

    always #5 clk = ~clk;

    // Presents one beat from a falling edge and returns at the next falling edge (one rising edge later).
    task automatic drive(input logic [7:0] d, input logic e);
        dataIn  = d;
        endIn   = e;
        validIn = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle();
        validIn = 1'b0;
        endIn   = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        checks++; if (readyIn !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 1", readyIn); end
        checks++; if (wordValid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", wordValid); end
        checks++; if (wordOut !== 32'h0) begin fails++; $display("[TB] FAIL reset_word: got %h expected 00000000", wordOut); end
        checks++; if (lenErr !== 1'b0) begin fails++; $display("[TB] FAIL reset_lenerr: got %b expected 0", lenErr); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_good_packet();
        wordReady = 1'b1;
        drive(8'h00, 1'b0);
        drive(8'h00, 1'b0);
        drive(8'h01, 1'b0);
        drive(8'h2C, 1'b1);
        checks++; if (wordValid !== 1'b1) begin fails++; $display("[TB] FAIL good_valid: got %b expected 1", wordValid); end
        checks++; if (wordOut !== 32'h0000012C) begin fails++; $display("[TB] FAIL good_word: got %h expected 0000012c", wordOut); end
        checks++; if (readyIn !== 1'b0) begin fails++; $display("[TB] FAIL good_ready_low: got %b expected 0", readyIn); end
        checks++; if (lenErr !== 1'b0) begin fails++; $display("[TB] FAIL good_lenerr: got %b expected 0", lenErr); end
        idle();
        checks++; if (wordValid !== 1'b0) begin fails++; $display("[TB] FAIL good_valid_drop: got %b expected 0", wordValid); end
        checks++; if (readyIn !== 1'b1) begin fails++; $display("[TB] FAIL good_ready_back: got %b expected 1", readyIn); end
        checks++; if (wordOut !== 32'h0000012C) begin fails++; $display("[TB] FAIL good_word_kept: got %h expected 0000012c", wordOut); end
    endtask

    task automatic test_backpressure();
        wordReady = 1'b0;
        drive(8'hDE, 1'b0);
        drive(8'hAD, 1'b0);
        drive(8'hBE, 1'b0);
        drive(8'hEF, 1'b1);
        // Offer the first byte of the next packet while the word is stalled.
        dataIn  = 8'h55;
        endIn   = 1'b0;
        validIn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (wordValid !== 1'b1) begin fails++; $display("[TB] FAIL bp_valid[%0d]: got %b expected 1", i, wordValid); end
            checks++; if (wordOut !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL bp_word[%0d]: got %h expected deadbeef", i, wordOut); end
            checks++; if (readyIn !== 1'b0) begin fails++; $display("[TB] FAIL bp_ready[%0d]: got %b expected 0", i, readyIn); end
            @(negedge clk);
        end
        wordReady = 1'b1;
        @(negedge clk);
        checks++; if (wordValid !== 1'b0) begin fails++; $display("[TB] FAIL bp_handshake_valid: got %b expected 0", wordValid); end
        checks++; if (readyIn !== 1'b1) begin fails++; $display("[TB] FAIL bp_handshake_ready: got %b expected 1", readyIn); end
        drive(8'h55, 1'b0);
        drive(8'h66, 1'b0);
        drive(8'h77, 1'b0);
        drive(8'h88, 1'b1);
        checks++; if (wordValid !== 1'b1) begin fails++; $display("[TB] FAIL bp_next_valid: got %b expected 1", wordValid); end
        checks++; if (wordOut !== 32'h55667788) begin fails++; $display("[TB] FAIL bp_next_word: got %h expected 55667788", wordOut); end
        idle();
        checks++; if (wordValid !== 1'b0) begin fails++; $display("[TB] FAIL bp_next_drop: got %b expected 0", wordValid); end
    endtask

    task automatic test_short_packet();
        wordReady = 1'b1;
        drive(8'h11, 1'b0);
        drive(8'h22, 1'b1);
        checks++; if (lenErr !== 1'b1) begin fails++; $display("[TB] FAIL short_lenerr: got %b expected 1", lenErr); end
        checks++; if (wordValid !== 1'b0) begin fails++; $display("[TB] FAIL short_valid: got %b expected 0", wordValid); end
        checks++; if (readyIn !== 1'b1) begin fails++; $display("[TB] FAIL short_ready: got %b expected 1", readyIn); end
        idle();
        checks++; if (lenErr !== 1'b0) begin fails++; $display("[TB] FAIL short_lenerr_pulse: got %b expected 0", lenErr); end
        drive(8'h01, 1'b0);
        drive(8'h02, 1'b0);
        drive(8'h03, 1'b0);
        drive(8'h04, 1'b1);
        checks++; if (wordValid !== 1'b1) begin fails++; $display("[TB] FAIL short_next_valid: got %b expected 1", wordValid); end
        checks++; if (wordOut !== 32'h01020304) begin fails++; $display("[TB] FAIL short_next_word: got %h expected 01020304", wordOut); end
        checks++; if (lenErr !== 1'b0) begin fails++; $display("[TB] FAIL short_next_lenerr: got %b expected 0", lenErr); end
        idle();
    endtask

    task automatic test_long_packet();
        wordReady = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            drive(8'(i), i == 6);
            if (i < 6) begin
                checks++; if (wordValid !== 1'b0) begin fails++; $display("[TB] FAIL long_valid[%0d]: got %b expected 0", i, wordValid); end
                checks++; if (lenErr !== 1'b0) begin fails++; $display("[TB] FAIL long_early_lenerr[%0d]: got %b expected 0", i, lenErr); end
            end
        end
        checks++; if (lenErr !== 1'b1) begin fails++; $display("[TB] FAIL long_lenerr: got %b expected 1", lenErr); end
        checks++; if (wordValid !== 1'b0) begin fails++; $display("[TB] FAIL long_end_valid: got %b expected 0", wordValid); end
        idle();
        checks++; if (lenErr !== 1'b0) begin fails++; $display("[TB] FAIL long_lenerr_pulse: got %b expected 0", lenErr); end
        drive(8'hA1, 1'b0);
        drive(8'hB2, 1'b0);
        drive(8'hC3, 1'b0);
        drive(8'hD4, 1'b1);
        checks++; if (wordOut !== 32'hA1B2C3D4) begin fails++; $display("[TB] FAIL long_next_word: got %h expected a1b2c3d4", wordOut); end
        checks++; if (wordValid !== 1'b1) begin fails++; $display("[TB] FAIL long_next_valid: got %b expected 1", wordValid); end
        idle();
    endtask

    task automatic test_over_by_one();
        wordReady = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            drive(8'(8'h20 + i), i == 5);
        end
        checks++; if (lenErr !== 1'b1) begin fails++; $display("[TB] FAIL over1_lenerr: got %b expected 1", lenErr); end
        checks++; if (wordValid !== 1'b0) begin fails++; $display("[TB] FAIL over1_valid: got %b expected 0", wordValid); end
        idle();
        checks++; if (lenErr !== 1'b0) begin fails++; $display("[TB] FAIL over1_lenerr_pulse: got %b expected 0", lenErr); end
        drive(8'h10, 1'b0);
        drive(8'h20, 1'b0);
        drive(8'h30, 1'b0);
        drive(8'h40, 1'b1);
        checks++; if (wordOut !== 32'h10203040) begin fails++; $display("[TB] FAIL over1_next_word: got %h expected 10203040", wordOut); end
        idle();
    endtask

    task automatic test_reset_in_hold();
        wordReady = 1'b0;
        drive(8'h0A, 1'b0);
        drive(8'h0B, 1'b0);
        drive(8'h0C, 1'b0);
        drive(8'h0D, 1'b1);
        validIn = 1'b0;
        endIn   = 1'b0;
        checks++; if (wordValid !== 1'b1) begin fails++; $display("[TB] FAIL hold_pre_valid: got %b expected 1", wordValid); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (wordValid !== 1'b0) begin fails++; $display("[TB] FAIL hold_rst_valid: got %b expected 0", wordValid); end
        checks++; if (wordOut !== 32'h0) begin fails++; $display("[TB] FAIL hold_rst_word: got %h expected 00000000", wordOut); end
        checks++; if (readyIn !== 1'b1) begin fails++; $display("[TB] FAIL hold_rst_ready: got %b expected 1", readyIn); end
        checks++; if (lenErr !== 1'b0) begin fails++; $display("[TB] FAIL hold_rst_lenerr: got %b expected 0", lenErr); end
        @(negedge clk);
        reset     = 1'b0;
        wordReady = 1'b1;
        @(negedge clk);
        checks++; if (wordValid !== 1'b0) begin fails++; $display("[TB] FAIL hold_post_valid: got %b expected 0", wordValid); end
        // A partial packet cut by reset must leave no stale bytes behind.
        drive(8'h77, 1'b0);
        drive(8'h88, 1'b0);
        validIn = 1'b0;
        reset   = 1'b1;
        #1;
        @(negedge clk);
        reset = 1'b0;
        drive(8'h01, 1'b0);
        drive(8'h02, 1'b0);
        drive(8'h03, 1'b0);
        drive(8'h04, 1'b1);
        checks++; if (wordValid !== 1'b1) begin fails++; $display("[TB] FAIL midrst_valid: got %b expected 1", wordValid); end
        checks++; if (wordOut !== 32'h01020304) begin fails++; $display("[TB] FAIL midrst_word: got %h expected 01020304", wordOut); end
        checks++; if (lenErr !== 1'b0) begin fails++; $display("[TB] FAIL midrst_lenerr: got %b expected 0", lenErr); end
        idle();
    endtask

`ifdef AVST_WORD_RX_ERRCNT_EN
    task automatic test_err_count();
        logic [1:0] expCount [5];
        expCount = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (errCount !== 2'd0) begin fails++; $display("[TB] FAIL errcnt_reset: got %0d expected 0", errCount); end
        for (int i = 0; i < 5; i++) begin
            drive(8'h11, 1'b0);
            drive(8'h22, 1'b1);
            checks++; if (errCount !== expCount[i]) begin fails++; $display("[TB] FAIL errcnt[%0d]: got %0d expected %0d", i, errCount, expCount[i]); end
            idle();
        end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        dataIn    = 8'h00;
        endIn     = 1'b0;
        validIn   = 1'b0;
        wordReady = 1'b0;
        test_reset();
        test_good_packet();
        test_backpressure();
        test_short_packet();
        test_long_packet();
        test_over_by_one();
        test_reset_in_hold();
`ifdef AVST_WORD_RX_ERRCNT_EN
        test_err_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
